// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared state encoding and control-unit opcodes for the memory responder.
package mem_responder_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        WAIT   = 2'b01,
        ACCESS = 2'b10,
        HOLD   = 2'b11
    } state_t;
    localparam logic [5:0] OP_LW = 6'b100011;
    localparam logic [5:0] OP_SW = 6'b101011;
endpackage

// File: rtl/mem_responder_ram.sv
// mem_responder_ram: synchronous single-port 32-bit word RAM, registered read every cycle.
module mem_responder_ram #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] idx,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);
    logic [31:0] mem [2**ADDR_W];
    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wdata;
        rdata <= mem[idx];
    end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: word RAM behind a level-strobe request with programmable wait states
// and a four-phase mem_ready/err handshake.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_r,
    input  logic        mem_w,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        mem_ready,
    output logic        busy,
    output logic        err
);
    state_t state, state_n;
    logic [3:0] cnt, cnt_n;
    logic op_w, op_w_n, ready_n, err_n;
    logic [ADDR_W-1:0] idx, idx_n, ram_idx;
    logic [31:0] wd, wd_n, rdata_n, ram_rdata;
    logic req, bad, unused;
    assign req = mem_r | mem_w;
    assign bad = (mem_r & mem_w) | (addr[1:0] != 2'b00);
    assign busy = state != IDLE;
    assign unused = ^addr[31:ADDR_W+2];
    // The RAM registers its read every cycle, so it must see the incoming index
    // while idle to have valid data by ACCESS even with zero wait states.
    assign ram_idx = (state == IDLE) ? addr[ADDR_W+1:2] : idx;
    mem_responder_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .we    (state == ACCESS && op_w),
        .idx   (ram_idx),
        .wdata (wd),
        .rdata (ram_rdata)
    );
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        op_w_n  = op_w;
        idx_n   = idx;
        wd_n    = wd;
        rdata_n = rdata;
        ready_n = mem_ready;
        err_n   = err;
        case (state)
            IDLE: if (req) begin
                op_w_n = mem_w;
                idx_n  = addr[ADDR_W+1:2];
                wd_n   = wdata;
                if (bad) begin
                    state_n = HOLD;
                    ready_n = 1'b1;
                    err_n   = 1'b1;
                end else if (WAIT_CYCLES == 0) begin
                    state_n = ACCESS;
                end else begin
                    state_n = WAIT;
                    cnt_n   = 4'(WAIT_CYCLES);
                end
            end
            WAIT: begin
                cnt_n   = cnt - 4'd1;
                state_n = (cnt <= 4'd1) ? ACCESS : WAIT;
            end
            ACCESS: begin
                rdata_n = op_w ? rdata : ram_rdata;
                ready_n = 1'b1;
                state_n = HOLD;
            end
            HOLD: if (!req) begin
                ready_n = 1'b0;
                err_n   = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            op_w      <= 1'b0;
            idx       <= '0;
            wd        <= '0;
            rdata     <= '0;
            mem_ready <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            op_w      <= op_w_n;
            idx       <= idx_n;
            wd        <= wd_n;
            rdata     <= rdata_n;
            mem_ready <= ready_n;
            err       <= err_n;
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed tests on two responders (2 and 0 wait states) against a
// transaction-timing model of the handshake.
module tb_mem_responder;
    import mem_responder_pkg::*;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic mem_r [2];
    logic mem_w [2];
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic mem_ready [2];
    logic busy [2];
    logic err [2];
    int checks = 0;
    int errors = 0;
    bit started = 0;
    always #5 clk = ~clk;
    mem_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .mem_r(mem_r[0]), .mem_w(mem_w[0]), .addr(addr[0]),
        .wdata(wdata[0]), .rdata(rdata[0]), .mem_ready(mem_ready[0]), .busy(busy[0]), .err(err[0]));
    mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .mem_r(mem_r[1]), .mem_w(mem_w[1]), .addr(addr[1]),
        .wdata(wdata[1]), .rdata(rdata[1]), .mem_ready(mem_ready[1]), .busy(busy[1]), .err(err[1]));
    // Model: a transaction is accepted at edge age 0; it completes (ready, memory effect)
    // at age wc+1, or at once if rejected; it retires on the first edge after ready with strobes low.
    int wc [2] = '{2, 0};
    bit act [2];
    bit is_err [2];
    bit is_rd [2];
    int age [2];
    logic [7:0] m_idx [2];
    logic [31:0] m_wd [2];
    logic [31:0] m_rdata [2];
    logic [31:0] m_mem [2][256];
    function automatic bit exp_ready(int d);
        return act[d] && (is_err[d] || age[d] >= wc[d] + 1);
    endfunction
    initial forever begin
        @(posedge clk or posedge reset);
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                act[d] = 0;
                m_rdata[d] = '0;
            end else if (!act[d]) begin
                if (mem_r[d] | mem_w[d]) begin
                    act[d] = 1;
                    age[d] = 0;
                    is_err[d] = (mem_r[d] & mem_w[d]) || addr[d][1:0] != 2'b00;
                    is_rd[d] = mem_r[d];
                    m_idx[d] = addr[d][9:2];
                    m_wd[d] = wdata[d];
                end
            end else if (exp_ready(d) && !(mem_r[d] | mem_w[d])) begin
                act[d] = 0;
            end else begin
                age[d]++;
                if (!is_err[d] && age[d] == wc[d] + 1) begin
                    if (is_rd[d]) m_rdata[d] = m_mem[d][m_idx[d]];
                    else m_mem[d][m_idx[d]] = m_wd[d];
                end
            end
        end
    end
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask
    initial forever begin
        @(negedge clk);
        if (started) for (int d = 0; d < 2; d++) begin
            chk($sformatf("busy%0d", d), 32'(busy[d]), 32'(act[d]));
            chk($sformatf("ready%0d", d), 32'(mem_ready[d]), 32'(exp_ready(d)));
            chk($sformatf("err%0d", d), 32'(err[d]), 32'(act[d] && is_err[d]));
            chk($sformatf("rdata%0d", d), rdata[d], m_rdata[d]);
        end
    end
    // Drive one request, measure edges from acceptance to mem_ready, hold strobes
    // for extra cycles, then drop them and expect mem_ready/busy low one edge later.
    task automatic txn(input int d, input bit r, input bit w, input logic [31:0] a,
                       input logic [31:0] wd, input int hold, input int exp_lat, input string name);
        int lat = -1;
        @(posedge clk); #1;
        mem_r[d] = r; mem_w[d] = w; addr[d] = a; wdata[d] = wd;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (mem_ready[d]) begin lat = k; break; end
        end
        chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
        repeat (hold) begin
            @(posedge clk); #1;
            chk({name, "_hold"}, 32'(mem_ready[d]), 32'd1);
        end
        mem_r[d] = 0; mem_w[d] = 0;
        @(posedge clk); #1;
        chk({name, "_ready_fall"}, 32'(mem_ready[d]), 32'd0);
        chk({name, "_idle"}, 32'(busy[d]), 32'd0);
    endtask
    initial begin
        for (int d = 0; d < 2; d++) begin
            mem_r[d] = 0; mem_w[d] = 0; addr[d] = '0; wdata[d] = '0;
        end
        #1 reset = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        started = 1;
        chk("reset_rdata", rdata[0], 32'h0);
        chk("reset_outs", {29'd0, mem_ready[0], busy[0], err[0]}, 32'h0);
        txn(0, 0, 1, 32'h10, 32'hDEADBEEF, 0, 3, "wr10");
        txn(0, 1, 0, 32'h10, 32'h0, 0, 3, "rd10");
        chk("rd10_data", rdata[0], 32'hDEADBEEF);
        txn(0, 0, 1, 32'h20, 32'h11111111, 0, 3, "wr20");
        fork
            txn(0, 1, 1, 32'h20, 32'h99999999, 0, 0, "both");
            begin @(posedge clk); #1; @(posedge clk); #1; chk("both_err", 32'(err[0]), 32'd1); end
        join
        txn(0, 1, 0, 32'h20, 32'h0, 0, 3, "rd20a");
        chk("rd20a_data", rdata[0], 32'h11111111);
        fork
            txn(0, 0, 1, 32'h22, 32'h77777777, 0, 0, "unal");
            begin @(posedge clk); #1; @(posedge clk); #1; chk("unal_err", 32'(err[0]), 32'd1); end
        join
        txn(0, 1, 0, 32'h20, 32'h0, 0, 3, "rd20b");
        chk("rd20b_data", rdata[0], 32'h11111111);
        txn(0, 1, 0, 32'h10, 32'h0, 5, 3, "hold");
        chk("hold_data", rdata[0], 32'hDEADBEEF);
        txn(0, 0, 1, 32'h40, 32'h13572468, 0, 3, "wr40");
        @(posedge clk); #1;
        mem_w[0] = 1; addr[0] = 32'h40; wdata[0] = 32'hCAFEF00D;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1;
        #1;
        chk("abort_rdata", rdata[0], 32'h0);
        chk("abort_outs", {29'd0, mem_ready[0], busy[0], err[0]}, 32'h0);
        mem_w[0] = 0;
        @(posedge clk); #1 reset = 0;
        txn(0, 1, 0, 32'h40, 32'h0, 0, 3, "rd40");
        chk("rd40_data", rdata[0], 32'h13572468);
        txn(0, 0, 1, 32'h400, 32'hA5A5A5A5, 0, 3, "wrap_wr");
        txn(0, 1, 0, 32'h0, 32'h0, 0, 3, "wrap_rd");
        chk("wrap_data", rdata[0], 32'hA5A5A5A5);
        txn(1, 0, 1, 32'h0, 32'h12345678, 0, 1, "z_wr");
        txn(1, 1, 0, 32'h0, 32'h0, 0, 1, "z_rd");
        chk("z_data", rdata[1], 32'h12345678);
        chk("opcodes", {26'd0, OP_LW ^ OP_SW}, 32'h8);
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multicycle datapath. It services the control unit's level-held mem_r/mem_w strobes against an internal word RAM.
- It inserts a programmable number of wait states and answers with a four-phase mem_ready handshake.
- It replaces the ideal zero-latency memory, so the control FSM can later stall on mem_ready.

Parameters:
- ADDR_W, 8, word-index width; RAM depth = 2**ADDR_W words of 32 bits.
- WAIT_CYCLES, 2, wait states inserted between request acceptance and access (0..15).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- mem_r  in  1  read request, level, held by requester until mem_ready seen.
- mem_w  in  1  write request, level, same rules as mem_r.
- addr  in  32  byte address; bits [ADDR_W+1:2] select word, upper bits ignored (wrap).
- wdata  in  32  write data; sampled with the request.
- rdata  out  32  read data; valid while mem_ready=1 after a read; held until the next read completes.
- mem_ready  out  1  access complete; level, held until both strobes are low.
- busy  out  1  high in any state other than IDLE.
- err  out  1  request rejected; level, same lifetime as mem_ready.

Behaviour:
- Reset (async, any state): state=IDLE, rdata=0, mem_ready=0, busy=0, err=0, wait counter=0. RAM contents are not cleared.
- Reset mid-request aborts the request. A write not yet in ACCESS never reaches RAM.
- FSM states: IDLE, WAIT, ACCESS, HOLD.
- IDLE:
  - On posedge with (mem_r|mem_w)=1, latch op, word index, and wdata; set busy.
  - Reject if mem_r&mem_w=1 or addr[1:0]!=0. Go to HOLD with err=1 and mem_ready=1. No RAM access; rdata unchanged.
  - Otherwise go to WAIT with counter=WAIT_CYCLES, or directly to ACCESS if WAIT_CYCLES=0.
- WAIT: counter decrements each cycle; at 1 go to ACCESS. Strobe or address changes during WAIT are ignored, because the latched values are used.
- ACCESS (one cycle):
  - Read: rdata <= RAM[idx].
  - Write: RAM[idx] <= wdata_latched.
  - Set mem_ready=1 and go to HOLD.
- HOLD: mem_ready (and err if set) stay high while mem_r|mem_w=1. On the first posedge with both low: clear mem_ready, err, and busy, then go to IDLE.
- Latency: acceptance edge N; mem_ready rises at edge N+WAIT_CYCLES+1. With 0 wait states it rises at N+1.
- Back-to-back requests: a new request is accepted only in IDLE, so there is at least one idle cycle between transactions.
- A strobe that rises while in HOLD is treated as a continuation of the current transaction (no new request).
- Read-after-write to the same word returns the new data.
- Address wrap: addr = 4*2**ADDR_W aliases word 0.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'b00, WAIT=2'b01, ACCESS=2'b10, HOLD=2'b11;
  - the opcode constants used by the control unit (LW=6'b100011, SW=6'b101011) for bench use.
- One sub-module is natural: mem_responder_ram, a synchronous single-port word RAM with clk, we, idx, wdata, rdata. The FSM lives in the top.

Test Plan:
- Reset then write/read: WAIT_CYCLES=2. Write wdata=32'hDEADBEEF to addr=32'h10, then read addr=32'h10. Required: mem_ready rises 3 edges after each acceptance; read returns rdata=32'hDEADBEEF; busy high throughout each transaction.
- Zero wait: WAIT_CYCLES=0. Read addr=0 after writing 32'h12345678. Required: mem_ready rises 1 edge after acceptance.
- Errors:
  - mem_r=mem_w=1 at addr=32'h20: err=1 and mem_ready=1 on the next edge; a subsequent read of 32'h20 returns the old value.
  - addr=32'h22: err=1; RAM unchanged.
- Handshake hold: keep mem_r high 5 cycles past mem_ready. Required: mem_ready stays 1 and no second access occurs; after mem_r drops, mem_ready falls on the next edge and busy=0.
- Reset mid-write: assert reset during WAIT of a write of 32'hCAFEF00D to addr=32'h40. Required: all outputs 0 immediately; a later read of 32'h40 returns the prior contents.
- Wrap: ADDR_W=8. Write 32'hA5A5A5A5 to addr=32'h400, then read addr=32'h0. Required: rdata=32'hA5A5A5A5.
